// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - byte-in / register-bank-out bundle for uart_cmd_ctrl
// Purpose: groups the received-byte strobe and the register/status outputs of the
//          command sequencer so they travel as one port.
// Signals:
//   rx_data   [7:0]        byte from the UART receiver, meaningful only with received
//   received               one-cycle byte strobe
//   regs      [8*NREGS-1:0] register bank, reg i = regs[8*i+7:8*i]
//   wr_stb                 one-cycle pulse after a register update
//   wr_addr   [3:0]        index of the most recently updated register
//   frame_err              one-cycle pulse after a rejected frame
//   err_count [7:0]        saturating rejected-frame counter
// Modports: slave = the sequencer, master = the byte source / observer.
interface uart_cmd_ctrl_if #(
   parameter int NREGS = 4
) ();
   logic [7:0]         rx_data;
   logic               received;
   logic [8*NREGS-1:0] regs;
   logic               wr_stb;
   logic [3:0]         wr_addr;
   logic               frame_err;
   logic [7:0]         err_count;

   modport slave (
      input  rx_data, received,
      output regs, wr_stb, wr_addr, frame_err, err_count
   );

   modport master (
      output rx_data, received,
      input  regs, wr_stb, wr_addr, frame_err, err_count
   );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART frame parser updating a small register bank
// Purpose: parses SYNC, CMD, ADDR, DATA[, CHK] frames from a received-byte strobe.
//          'W' writes, 'S' ORs, 'C' AND-clears a register; bad frames pulse frame_err
//          and bump a saturating counter; an inter-byte idle gap aborts a frame.
// Ports:
//   clk    posedge system clock
//   rst_n  synchronous active-low reset
//   bus    uart_cmd_ctrl_if.slave: rx_data/received in; regs, wr_stb, wr_addr,
//          frame_err, err_count out (all outputs registered)
// Build option: UART_CMD_CHECKSUM_EN adds a CHK byte that must equal CMD^ADDR^DATA.
module uart_cmd_ctrl #(
   parameter int         CLK_FREQ      = 12_000_000,
   parameter int         BAUDRATE      = 921_600,
   parameter int         TIMEOUT_BYTES = 4,
   parameter logic [7:0] SYNC_BYTE     = 8'hA5,
   parameter int         NREGS         = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_cmd_ctrl_if.slave bus
);

   // Idle gap in clocks: TIMEOUT_BYTES byte-times of 10 bits each.
   localparam longint TMO_RAW  = (longint'(TIMEOUT_BYTES) * 10 * longint'(CLK_FREQ)) / longint'(BAUDRATE);
   localparam int     TMO      = (TMO_RAW < 1) ? 1 : int'(TMO_RAW);
   localparam int     CW       = $clog2(TMO + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_S = 8'h53;
   localparam logic [7:0] CMD_C = 8'h43;

`ifdef UART_CMD_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_CMD, S_ADDR, S_DATA} state_t;
`endif

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [7:0]         cmd_q, addr_q;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]         data_q;
   logic               ld_data;
`endif
   logic [8*NREGS-1:0] regs_q;
   logic               wr_stb_q, frame_err_q;
   logic [3:0]         wr_addr_q;
   logic [7:0]         err_q;

   logic               ld_cmd, ld_addr, fin, bad_cmd, tmo_hit;
   logic               frame_ok, do_wr, do_err;
   logic [7:0]         fin_data;

   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      ld_cmd   = 1'b0;
      ld_addr  = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      ld_data  = 1'b0;
`endif
      fin      = 1'b0;
      bad_cmd  = 1'b0;
      tmo_hit  = 1'b0;
      frame_ok = 1'b0;
      do_wr    = 1'b0;
      do_err   = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      fin_data = data_q;
`else
      fin_data = bus.rx_data;
`endif

      if (bus.received) begin
         // A byte always restarts the idle timer, even on the expiry cycle.
         unique case (state_q)
            S_IDLE: if (bus.rx_data == SYNC_BYTE) state_d = S_CMD;
            S_CMD: begin
               if (bus.rx_data inside {CMD_W, CMD_S, CMD_C}) begin
                  ld_cmd  = 1'b1;
                  state_d = S_ADDR;
               end else begin
                  bad_cmd = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_ADDR: begin
               ld_addr = 1'b1;
               state_d = S_DATA;
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_DATA: begin
               ld_data = 1'b1;
               state_d = S_CHK;
            end
            S_CHK: begin
               fin     = 1'b1;
               state_d = S_IDLE;
            end
`else
            S_DATA: begin
               fin     = 1'b1;
               state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE) begin
         if (cnt_q == TMO_LAST) begin
            tmo_hit = 1'b1;
            state_d = S_IDLE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      frame_ok = ({1'b0, addr_q} < 9'(NREGS));
`ifdef UART_CMD_CHECKSUM_EN
      frame_ok = frame_ok && (bus.rx_data == (cmd_q ^ addr_q ^ data_q));
`endif
      do_wr  = fin && frame_ok;
      do_err = bad_cmd || tmo_hit || (fin && !frame_ok);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cmd_q       <= '0;
         addr_q      <= '0;
`ifdef UART_CMD_CHECKSUM_EN
         data_q      <= '0;
`endif
         regs_q      <= '0;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= '0;
         frame_err_q <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         if (ld_cmd)  cmd_q  <= bus.rx_data;
         if (ld_addr) addr_q <= bus.rx_data;
`ifdef UART_CMD_CHECKSUM_EN
         if (ld_data) data_q <= bus.rx_data;
`endif
         wr_stb_q    <= do_wr;
         frame_err_q <= do_err;
         if (do_wr) begin
            wr_addr_q <= addr_q[3:0];
            for (int i = 0; i < NREGS; i++) begin
               if (addr_q[3:0] == 4'(i)) begin
                  unique case (cmd_q)
                     CMD_S:   regs_q[8*i +: 8] <= regs_q[8*i +: 8] | fin_data;
                     CMD_C:   regs_q[8*i +: 8] <= regs_q[8*i +: 8] & ~fin_data;
                     default: regs_q[8*i +: 8] <= fin_data;
                  endcase
               end
            end
         end
         if (do_err && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
      end
   end

   assign bus.regs      = regs_q;
   assign bus.wr_stb    = wr_stb_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.frame_err = frame_err_q;
   assign bus.err_count = err_q;

endmodule
